// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: start/done handshake and operand/result bus; SUB_SIGNED_OVF_EN adds ovf
interface nibble_serial_subtractor_if #(parameter int WIDTH = 16);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bw_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bw_out;
`ifdef SUB_SIGNED_OVF_EN
    logic             ovf;
    modport master (output start, A, B, Bw_in, input busy, done, Diff, Bw_out, ovf);
    modport slave  (input start, A, B, Bw_in, output busy, done, Diff, Bw_out, ovf);
`else
    modport master (output start, A, B, Bw_in, input busy, done, Diff, Bw_out);
    modport slave  (input start, A, B, Bw_in, output busy, done, Diff, Bw_out);
`endif
endinterface

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: A - B - Bw_in one CLA nibble per clock, LSB first; SUB_SIGNED_OVF_EN adds signed overflow flag
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input logic clk,
    input logic rst,
    nibble_serial_subtractor_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, next;
    logic [WIDTH-1:0] a_q, b_q;
    logic [CW-1:0]    cnt;
    logic             borrow;
    logic [3:0]       a_n, nb, p, g, c, s;
    logic             c4, last;
    assign a_n  = a_q[3:0];
    assign nb   = ~b_q[3:0];
    assign p    = a_n ^ nb;
    assign g    = a_n & nb;
    assign c[0] = ~borrow;
    assign c[1] = g[0] | (p[0] & c[0]);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    assign c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) | (&p & c[0]);
    assign s    = p ^ c;
    assign last = cnt == CW'(N - 1);
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next;
    end
    // accept on start in IDLE, return to IDLE after the last nibble
    always_comb begin
        next = state;
        next = (state == IDLE) ? (bus.start ? RUN : IDLE) : (last ? IDLE : RUN);
    end
    // operand latch, nibble datapath and handshake outputs; operands shift right so the live nibble is always [3:0]
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            cnt        <= '0;
            borrow     <= 1'b0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.Diff   <= '0;
            bus.Bw_out <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
            bus.ovf    <= 1'b0;
`endif
        end else begin
            bus.done <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    a_q      <= bus.A;
                    b_q      <= bus.B;
                    borrow   <= bus.Bw_in;
                    cnt      <= '0;
                    bus.Diff <= '0;
                    bus.busy <= 1'b1;
                end
            end else begin
                bus.Diff[{cnt, 2'b00} +: 4] <= s;
                borrow <= ~c4;
                a_q    <= a_q >> 4;
                b_q    <= b_q >> 4;
                cnt    <= cnt + 1'b1;
                if (last) begin
                    bus.Bw_out <= ~c4;
                    bus.done   <= 1'b1;
                    bus.busy   <= 1'b0;
`ifdef SUB_SIGNED_OVF_EN
                    bus.ovf    <= (a_n[3] ^ b_q[3]) & (s[3] ^ a_n[3]);
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed vector table plus handshake/reset sequences for the 16-bit serial subtractor
module tb_nibble_serial_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   lat;
    nibble_serial_subtractor_if #(.WIDTH(16)) bus ();
    nibble_serial_subtractor #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bw;
        logic [15:0] diff;
        logic        bwo;
        logic        ovf;
    } vec_t;
    vec_t vecs [10];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 12) begin
            if (bus.busy !== 1'b1) begin
                tests++;
                fails++;
                $display("FAIL busy_run: got %b expected 1 at edge %0d", bus.busy, n);
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask
    task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic bw);
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        bus.Bw_in = bw;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A     = 16'h5A5A;
        bus.B     = 16'hA5A5;
        bus.Bw_in = 1'b1;
    endtask
    initial begin
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        bus.Bw_in = 1'b0;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h0010, 16'h0000, 1'b1, 16'h000F, 1'b0, 1'b0};
        vecs[3] = '{16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[5] = '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[6] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[7] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[8] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0};
        vecs[9] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_busy", {31'd0, bus.busy}, 32'd0);
        chk("reset_done", {31'd0, bus.done}, 32'd0);
        chk("reset_diff", {16'd0, bus.Diff}, 32'd0);
        chk("reset_bwout", {31'd0, bus.Bw_out}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
        chk("reset_ovf", {31'd0, bus.ovf}, 32'd0);
`endif
        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].bw);
            chk($sformatf("v%0d_busy_acc", i), {31'd0, bus.busy}, 32'd1);
            wait_done(lat);
            chk($sformatf("v%0d_latency", i), lat, 32'd4);
            chk($sformatf("v%0d_diff", i), {16'd0, bus.Diff}, {16'd0, vecs[i].diff});
            chk($sformatf("v%0d_bwout", i), {31'd0, bus.Bw_out}, {31'd0, vecs[i].bwo});
            chk($sformatf("v%0d_busy_done", i), {31'd0, bus.busy}, 32'd0);
`ifdef SUB_SIGNED_OVF_EN
            chk($sformatf("v%0d_ovf", i), {31'd0, bus.ovf}, {31'd0, vecs[i].ovf});
`endif
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), {31'd0, bus.done}, 32'd0);
            chk($sformatf("v%0d_diff_hold", i), {16'd0, bus.Diff}, {16'd0, vecs[i].diff});
        end
        accept(16'hABCD, 16'h1234, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_mid_done", {31'd0, bus.done}, 32'd0);
        chk("rst_mid_diff", {16'd0, bus.Diff}, 32'd0);
        chk("rst_mid_bwout", {31'd0, bus.Bw_out}, 32'd0);
        repeat (6) begin
            @(posedge clk);
            #1;
            tests++;
            if (bus.done !== 1'b0) begin
                fails++;
                $display("FAIL rst_no_done: got %b expected 0", bus.done);
            end
        end
        accept(16'hABCD, 16'h1234, 1'b0);
        wait_done(lat);
        chk("post_rst_latency", lat, 32'd4);
        chk("post_rst_diff", {16'd0, bus.Diff}, 32'h9999);
        accept(16'h1234, 16'h0234, 1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.A     = 16'hFFFF;
        bus.B     = 16'h0000;
        bus.Bw_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done(lat);
        chk("ignore_latency", lat, 32'd2);
        chk("ignore_diff", {16'd0, bus.Diff}, 32'h1000);
        chk("ignore_bwout", {31'd0, bus.Bw_out}, 32'd0);
        bus.start = 1'b1;
        bus.A     = 16'h0000;
        bus.B     = 16'h0001;
        bus.Bw_in = 1'b0;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_accept_busy", {31'd0, bus.busy}, 32'd1);
        chk("b2b_accept_done", {31'd0, bus.done}, 32'd0);
        wait_done(lat);
        chk("b2b_latency", lat, 32'd4);
        chk("b2b_diff", {16'd0, bus.Diff}, 32'hFFFF);
        chk("b2b_bwout", {31'd0, bus.Bw_out}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
